// File: rtl/gsu_pkg.sv
// Shared types and constants for the GSU instruction cache controller.
package gsu_pkg;

    localparam int LINE_BYTES  = 16;
    localparam int NUM_LINES   = 32;
    localparam int CACHE_BYTES = 512;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DATA,
        FILL,
        UNCACHED,
        ACK
    } state_t;

    // Cache-relative offset of a PC; wraps modulo 2^16 by construction.
    function automatic logic [15:0] cache_offset(input logic [15:0] addr,
                                                 input logic [15:0] base);
        return addr - base;
    endfunction

endpackage

// File: rtl/gsu_cache_flags.sv
// Per-line valid bits; flush (clear all) beats any same-cycle set.
module gsu_cache_flags
    import gsu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 set_a,
    input  logic [4:0]           idx_a,
    input  logic                 set_b,
    input  logic [4:0]           idx_b,
    output logic [NUM_LINES-1:0] flags
);

    logic [NUM_LINES-1:0] set_mask;

    always_comb begin
        set_mask = '0;
        if (set_a) set_mask[idx_a] = 1'b1;
        if (set_b) set_mask[idx_b] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags <= '0;
        end else if (flush) begin
            flags <= '0;
        end else begin
            flags <= flags | set_mask;
        end
    end

endmodule

// File: rtl/gsu_cache_ctrl.sv
// GSU instruction cache controller: 512-byte cache of 32 lines, whole-line
// fills from external memory, uncached bypass outside the window.
module gsu_cache_ctrl
    import gsu_pkg::*;
(
    input  logic        clkin,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic [15:0] fetch_addr,
    input  logic [7:0]  pbr,
    input  logic [15:0] cbr,
    output logic        fetch_ack,
    output logic [7:0]  fetch_data,
    input  logic        flush,
    input  logic        snes_line_set,
    input  logic [4:0]  snes_line_idx,
    output logic [31:0] cache_flags,
    output logic [8:0]  cache_addr,
    output logic        cache_we,
    output logic [7:0]  cache_wdata,
    input  logic [7:0]  cache_rdata,
    output logic        mem_req,
    output logic [23:0] mem_addr,
    input  logic        mem_rdy,
    input  logic [7:0]  mem_data,
    output logic        busy
);

    state_t      state, state_nxt;
    logic [15:0] offset;
    logic        cacheable;
    logic        hit;
    logic        fill_done;
    logic        flush_pend;
    logic [3:0]  idx_q;
    logic [7:0]  data_q;
    logic [4:0]  line_q;
    logic [3:0]  byte_q;
    logic [7:0]  pbr_q;
    logic [15:0] addr_q;
    logic [15:0] base_q;

    assign offset    = cache_offset(fetch_addr, cbr);
    assign cacheable = (offset < 16'(CACHE_BYTES));
    assign hit       = cacheable && cache_flags[offset[8:4]];
    assign fill_done = (state == FILL) && mem_rdy && (idx_q == 4'(LINE_BYTES - 1));

    always_ff @(posedge clkin) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (fetch_req) begin
                    if (hit)            state_nxt = READ;
                    else if (cacheable) state_nxt = FILL;
                    else                state_nxt = UNCACHED;
                end
            end
            READ:     state_nxt = DATA;
            DATA:     state_nxt = IDLE;
            FILL:     if (fill_done) state_nxt = ACK;
            UNCACHED: if (mem_rdy)   state_nxt = ACK;
            ACK:      state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != IDLE);
        fetch_ack   = 1'b0;
        fetch_data  = data_q;
        cache_addr  = '0;
        cache_we    = 1'b0;
        cache_wdata = '0;
        mem_req     = 1'b0;
        mem_addr    = '0;
        case (state)
            IDLE: begin
                // Present the read address early so the RAM's one-cycle
                // latency is hidden behind READ.
                if (fetch_req && hit) cache_addr = offset[8:0];
            end
            READ: begin
                cache_addr = {line_q, byte_q};
            end
            DATA: begin
                cache_addr = {line_q, byte_q};
                fetch_ack  = 1'b1;
                fetch_data = cache_rdata;
            end
            FILL: begin
                mem_req  = 1'b1;
                mem_addr = {pbr_q, 16'(base_q + {7'd0, line_q, idx_q})};
                if (mem_rdy) begin
                    cache_we    = 1'b1;
                    cache_addr  = {line_q, idx_q};
                    cache_wdata = mem_data;
                end
            end
            UNCACHED: begin
                mem_req  = 1'b1;
                mem_addr = {pbr_q, addr_q};
            end
            ACK: begin
                fetch_ack = 1'b1;
            end
            default: ;
        endcase
    end

    // Beat counter, returned byte and the "flushed during this fill" marker.
    always_ff @(posedge clkin) begin
        if (rst) begin
            idx_q      <= '0;
            data_q     <= '0;
            flush_pend <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    idx_q      <= '0;
                    flush_pend <= 1'b0;
                end
                DATA: data_q <= cache_rdata;
                FILL: begin
                    if (flush) flush_pend <= 1'b1;
                    if (mem_rdy) begin
                        idx_q <= idx_q + 4'd1;
                        if (idx_q == byte_q) data_q <= mem_data;
                    end
                end
                UNCACHED: if (mem_rdy) data_q <= mem_data;
                default: ;
            endcase
        end
    end

    // Request operands are only meaningful once captured in IDLE.
    always_ff @(posedge clkin) begin
        if (state == IDLE) begin
            line_q <= offset[8:4];
            byte_q <= offset[3:0];
            pbr_q  <= pbr;
            addr_q <= fetch_addr;
            base_q <= cbr;
        end
    end

    gsu_cache_flags u_flags (
        .clk   (clkin),
        .rst   (rst),
        .flush (flush),
        .set_a (snes_line_set),
        .idx_a (snes_line_idx),
        .set_b (fill_done && !flush_pend),
        .idx_b (line_q),
        .flags (cache_flags)
    );

endmodule

// File: tb/tb_gsu_cache_ctrl.sv
// Directed bench for gsu_cache_ctrl with cache RAM, external memory model
// and a scoreboard of expected fetch bytes.
module tb_gsu_cache_ctrl;

    logic        clkin = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic [7:0]  pbr;
    logic [15:0] cbr;
    logic        fetch_ack;
    logic [7:0]  fetch_data;
    logic        flush;
    logic        snes_line_set;
    logic [4:0]  snes_line_idx;
    logic [31:0] cache_flags;
    logic [8:0]  cache_addr;
    logic        cache_we;
    logic [7:0]  cache_wdata;
    logic [7:0]  cache_rdata;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic        mem_rdy;
    logic [7:0]  mem_data;
    logic        busy;

    gsu_cache_ctrl dut (
        .clkin         (clkin),
        .rst           (rst),
        .fetch_req     (fetch_req),
        .fetch_addr    (fetch_addr),
        .pbr           (pbr),
        .cbr           (cbr),
        .fetch_ack     (fetch_ack),
        .fetch_data    (fetch_data),
        .flush         (flush),
        .snes_line_set (snes_line_set),
        .snes_line_idx (snes_line_idx),
        .cache_flags   (cache_flags),
        .cache_addr    (cache_addr),
        .cache_we      (cache_we),
        .cache_wdata   (cache_wdata),
        .cache_rdata   (cache_rdata),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_rdy       (mem_rdy),
        .mem_data      (mem_data),
        .busy          (busy)
    );

    always #5 clkin = ~clkin;

    int          vecs = 0;
    int          errs = 0;
    int          wr_count = 0;
    bit          mem_auto = 1'b0;
    logic [7:0]  exp_q[$];
    logic [23:0] got_addr[$];

    // Cache RAM: one-cycle read latency, bench-side preload port.
    logic [7:0] ram [0:511];
    logic       pre_we = 1'b0;
    logic [8:0] pre_addr = '0;
    logic [7:0] pre_data = '0;

    always @(posedge clkin) begin
        if (cache_we === 1'b1) ram[cache_addr] <= cache_wdata;
        else if (pre_we)       ram[pre_addr]   <= pre_data;
        cache_rdata <= ram[cache_addr];
    end

    always @(posedge clkin) begin
        if (cache_we === 1'b1) wr_count <= wr_count + 1;
    end

    function automatic logic [7:0] memf(input logic [23:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ a[23:16] ^ 8'h5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // External memory: answers each pending request one cycle later.
    initial begin
        forever begin
            @(negedge clkin);
            if (mem_auto) begin
                if (mem_req === 1'b1 && mem_rdy !== 1'b1) begin
                    mem_rdy  = 1'b1;
                    mem_data = memf(mem_addr);
                    got_addr.push_back(mem_addr);
                end else begin
                    mem_rdy = 1'b0;
                end
            end
        end
    end

    // Scoreboard: every ack must match the oldest expected byte.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clkin);
            if (fetch_ack === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_data", 32'(fetch_data), 32'(e));
                end
            end
        end
    end

    // Issue one fetch; optional checks on ack latency, early cache address, flush beat.
    task automatic fetch(input logic [15:0] a, input logic [7:0] p, input logic [15:0] c,
                         input logic [7:0] exp, input int exp_cyc, input int flush_at,
                         input int exp_caddr, input string tag);
        int cyc;
        int w0;
        bit fl_done;
        exp_q.push_back(exp);
        w0 = wr_count;
        fl_done = 1'b0;
        fetch_addr = a;
        pbr = p;
        cbr = c;
        fetch_req = 1'b1;
        cyc = 0;
        if (exp_caddr >= 0) begin
            #1;
            chk({tag, "_cache_addr"}, 32'(cache_addr), 32'(exp_caddr));
        end
        while (fetch_ack !== 1'b1 && cyc < 300) begin
            @(negedge clkin);
            cyc++;
            flush = 1'b0;
            if (flush_at >= 0 && !fl_done && (wr_count - w0) == flush_at) begin
                flush = 1'b1;
                fl_done = 1'b1;
            end
        end
        flush = 1'b0;
        if (cyc >= 300) begin
            chk({tag, "_ack_timeout"}, 32'd0, 32'd1);
            exp_q.delete();
        end else if (exp_cyc >= 0) begin
            chk({tag, "_ack_cycle"}, 32'(cyc), 32'(exp_cyc));
        end
        fetch_req = 1'b0;
        @(negedge clkin);
        chk({tag, "_ack_pulse"}, 32'(fetch_ack), 32'd0);
    endtask

    initial begin
        int w0;
        int k;
        rst = 1'b1;
        fetch_req = 1'b0;
        fetch_addr = '0;
        pbr = '0;
        cbr = '0;
        flush = 1'b0;
        snes_line_set = 1'b0;
        snes_line_idx = '0;
        mem_rdy = 1'b0;
        mem_data = '0;
        repeat (3) @(negedge clkin);

        chk("rst_flags", cache_flags, 32'd0);
        chk("rst_ack", 32'(fetch_ack), 32'd0);
        chk("rst_fetch_data", 32'(fetch_data), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_cache_we", 32'(cache_we), 32'd0);
        chk("rst_cache_addr", 32'(cache_addr), 32'd0);
        chk("rst_cache_wdata", 32'(cache_wdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        mem_auto = 1'b1;
        @(negedge clkin);

        // Hit on a line marked valid by the SNES side
        pre_we = 1'b1;
        pre_addr = 9'h025;
        pre_data = 8'hC3;
        snes_line_set = 1'b1;
        snes_line_idx = 5'd2;
        @(negedge clkin);
        pre_we = 1'b0;
        snes_line_set = 1'b0;
        chk("hit_flag_set", cache_flags, 32'h0000_0004);
        fetch(16'h0025, 8'h00, 16'h0000, 8'hC3, 2, -1, 'h025, "hit");

        // Miss: whole-line fill
        got_addr.delete();
        w0 = wr_count;
        fetch(16'h8013, 8'h01, 16'h8000, memf(24'h018013), -1, -1, -1, "fill");
        chk("fill_beats", 32'(got_addr.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            if (i < got_addr.size())
                chk("fill_mem_addr", 32'(got_addr[i]), 32'h0001_8010 + 32'(i));
        end
        chk("fill_writes", 32'(wr_count - w0), 32'd16);
        chk("fill_flags", cache_flags, 32'h0000_0006);
        chk("fill_ram_byte", 32'(ram[9'h013]), 32'(memf(24'h018013)));
        fetch(16'h801A, 8'h01, 16'h8000, memf(24'h01801A), 2, -1, 'h01A, "refill_hit");

        // Fill whose external addresses wrap within the bank
        got_addr.delete();
        fetch(16'h0005, 8'h02, 16'hFF00, memf(24'h020005), -1, -1, -1, "wrap");
        chk("wrap_beats", 32'(got_addr.size()), 32'd16);
        if (got_addr.size() == 16) begin
            chk("wrap_first_addr", 32'(got_addr[0]), 32'h0002_0000);
            chk("wrap_last_addr", 32'(got_addr[15]), 32'h0002_000F);
        end
        chk("wrap_flags", cache_flags, 32'h0001_0006);

        // Outside the cache window
        got_addr.delete();
        w0 = wr_count;
        fetch(16'h0200, 8'h01, 16'h0000, memf(24'h010200), -1, -1, -1, "uncached");
        chk("uncached_beats", 32'(got_addr.size()), 32'd1);
        if (got_addr.size() == 1) chk("uncached_addr", 32'(got_addr[0]), 32'h0001_0200);
        chk("uncached_writes", 32'(wr_count - w0), 32'd0);
        chk("uncached_flags", cache_flags, 32'h0001_0006);

        // Flush during a fill
        w0 = wr_count;
        fetch(16'h0043, 8'h00, 16'h0000, memf(24'h000043), -1, 4, -1, "flushfill");
        chk("flushfill_writes", 32'(wr_count - w0), 32'd16);
        chk("flushfill_flags", cache_flags, 32'd0);
        chk("flushfill_line4", 32'(cache_flags[4]), 32'd0);

        // snes_line_set alone and against flush
        snes_line_set = 1'b1;
        snes_line_idx = 5'd3;
        @(negedge clkin);
        chk("snes3_flags", cache_flags, 32'h0000_0008);
        snes_line_idx = 5'd7;
        flush = 1'b1;
        @(negedge clkin);
        flush = 1'b0;
        chk("snes7_flush_flags", cache_flags, 32'd0);
        @(negedge clkin);
        snes_line_set = 1'b0;
        chk("snes7_flags", cache_flags, 32'h0000_0080);

        // Reset part-way through a fill
        mem_auto = 1'b0;
        mem_rdy = 1'b0;
        w0 = wr_count;
        fetch_addr = 16'h0031;
        pbr = 8'h00;
        cbr = 16'h0000;
        fetch_req = 1'b1;
        for (int b = 0; b < 3; b++) begin
            k = 0;
            while (mem_req !== 1'b1 && k < 20) begin
                @(negedge clkin);
                k++;
            end
            if (k >= 20) chk("rstfill_req_timeout", 32'd0, 32'd1);
            mem_rdy = 1'b1;
            mem_data = memf(mem_addr);
            @(negedge clkin);
            mem_rdy = 1'b0;
        end
        chk("rstfill_writes_before", 32'(wr_count - w0), 32'd3);
        rst = 1'b1;
        fetch_req = 1'b0;
        @(negedge clkin);
        chk("rstfill_mem_req", 32'(mem_req), 32'd0);
        chk("rstfill_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        mem_rdy = 1'b1;
        mem_data = 8'hAA;
        #1;
        chk("rstfill_late_rdy_we", 32'(cache_we), 32'd0);
        @(negedge clkin);
        mem_rdy = 1'b0;
        repeat (3) @(negedge clkin);
        chk("rstfill_writes_after", 32'(wr_count - w0), 32'd3);
        chk("rstfill_flags", cache_flags, 32'd0);
        chk("rstfill_idle", 32'(busy), 32'd0);
        chk("rstfill_no_pending", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
